// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response side and
// decoder-facing instruction handshake plus the decoder's redirect inputs.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        is_jump;
    logic        is_branch;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        output instruction, instr_pc, instr_valid,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  instr_ready, is_jump, is_branch, branch_taken,
        input  imm16, addr26, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  instruction, instr_pc, instr_valid,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output instr_ready, is_jump, is_branch, branch_taken,
        output imm16, addr26, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, small instruction
// FIFO toward the decoder, jump/branch redirect with stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic         clk,
    input logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [31:0]     fetch_pc, resp_pc;
    logic [CW-1:0]   count, outst, drop, outst_n;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     q_data [BUF_DEPTH];
    logic [31:0]     q_pc   [BUF_DEPTH];

    logic            req_valid, room, accept, resp, keep;
    logic            valid, consume, redir;
    logic [31:0]     head_pc, pc4, boff, target, tgt;
    logic [CW:0]     used;

    assign used = {1'b0, count} + {1'b0, outst};
    assign room = used < (CW+1)'(BUF_DEPTH);

    always_comb begin
        state_n   = state;
        req_valid = 1'b0;
        unique case (state)
            IDLE: state_n = RUN;
            RUN: begin
                state_n   = RUN;
                req_valid = room;
            end
        endcase
    end

    assign accept  = req_valid & bus.imem_req_ready;
    assign resp    = bus.imem_resp_valid;
    assign keep    = resp & (drop == '0);
    assign valid   = count != '0;
    assign consume = valid & bus.instr_ready;
    assign head_pc = q_pc[rd_ptr];
    assign pc4     = head_pc + 32'd4;
    assign boff    = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign outst_n = outst + CW'(accept) - CW'(resp);

    // Register jumps win over J-format, which win over taken branches.
    always_comb begin
        redir  = 1'b0;
        target = pc4;
        if (consume) begin
            if (bus.redirect_valid) begin
                redir  = 1'b1;
                target = bus.redirect_pc;
            end else if (bus.is_jump) begin
                redir  = 1'b1;
                target = {pc4[31:28], bus.addr26, 2'b00};
            end else if (bus.is_branch && bus.branch_taken) begin
                redir  = 1'b1;
                target = pc4 + boff;
            end
        end
    end

    assign tgt = {target[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            outst    <= '0;
            drop     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= state_n;
            outst <= outst_n;
            if (redir) begin
                // Everything still in flight was fetched down the old path.
                fetch_pc <= tgt;
                resp_pc  <= tgt;
                drop     <= outst_n;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp && drop != '0)
                    drop <= drop - CW'(1);
                if (keep) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (consume)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(keep) - CW'(consume);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (keep && !redir) begin
            q_data[wr_ptr] <= bus.imem_resp_data;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = valid;
    assign bus.instruction    = valid ? q_data[rd_ptr] : 32'd0;
    assign bus.instr_pc       = valid ? head_pc : 32'd0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based memory and program-flow model,
// directed redirect scenarios, then randomized traffic with a reset.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        reqq[$];
    logic [31:0] fifo[$];
    logic [31:0] fpc;
    bit          running;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          ready_pct = 100;
    int          vectors = 0, miscompares = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        reqq.delete();
        fifo.delete();
        fpc     = 32'h0;
        running = 1'b0;
    endtask

    // Program-flow model: a word's PC is simply the address it was fetched
    // from; a redirect empties the queue and poisons every pending fetch.
    task automatic model_update();
        bit          can_req, acc, cons, flush;
        logic [31:0] tgt, pc4;
        req_t        r, nr;
        can_req = running && (fifo.size() + reqq.size() < 2);
        acc     = can_req && bus.imem_req_ready;
        cons    = (fifo.size() > 0) && bus.instr_ready;
        flush   = 1'b0;
        tgt     = 32'h0;
        if (cons) begin
            pc4 = fifo[0] + 32'd4;
            if (bus.redirect_valid) begin
                flush = 1'b1;
                tgt   = bus.redirect_pc;
            end else if (bus.is_jump) begin
                flush = 1'b1;
                tgt   = {pc4[31:28], bus.addr26, 2'b00};
            end else if (bus.is_branch && bus.branch_taken) begin
                flush = 1'b1;
                tgt   = pc4 + 32'(signed'(bus.imm16)) * 4;
            end
            tgt[1:0] = 2'b00;
            void'(fifo.pop_front());
        end
        if (bus.imem_resp_valid && reqq.size() > 0) begin
            r = reqq.pop_front();
            if (!r.stale)
                fifo.push_back(r.addr);
        end
        if (flush) begin
            fifo.delete();
            foreach (reqq[i]) reqq[i].stale = 1'b1;
        end
        cyc++;
        if (acc) begin
            nr.addr  = fpc;
            nr.due   = cyc + $urandom_range(lat_max, lat_min) - 1;
            nr.stale = flush;
            reqq.push_back(nr);
            fpc = fpc + 32'd4;
        end
        if (flush)
            fpc = tgt;
        running = 1'b1;
    endtask

    task automatic compare();
        bit ev;
        bit ne;
        ev = running && (fifo.size() + reqq.size() < 2);
        ne = fifo.size() > 0;
        chk("req_valid", bus.imem_req_valid, ev);
        chk("req_addr", bus.imem_req_addr, fpc);
        chk("instr_valid", bus.instr_valid, ne);
        chk("instr_pc", bus.instr_pc, ne ? fifo[0] : 32'h0);
        chk("instruction", bus.instruction, ne ? fifo[0] ^ KEY : 32'h0);
    endtask

    task automatic drive_mem();
        bus.imem_req_ready = $urandom_range(99, 0) < ready_pct;
        if (reqq.size() > 0 && reqq[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = reqq[0].addr ^ KEY;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
        end
    endtask

    task automatic set_dec(bit rd, bit rv, logic [31:0] rpc, bit j,
                           logic [25:0] a26, bit b, bit t,
                           logic [15:0] imm);
        bus.instr_ready    = rd;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.is_jump        = j;
        bus.addr26         = a26;
        bus.is_branch      = b;
        bus.branch_taken   = t;
        bus.imm16          = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
        drive_mem();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        bus.imem_resp_valid = 1'b0;
        #1 compare();
        chk("rst_instr_valid", bus.instr_valid, 32'h0);
        chk("rst_req_valid", bus.imem_req_valid, 32'h0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare();
        drive_mem();
    endtask

    // Consume the next presented word with the given decoder fields and
    // return the PC the DUT showed for it.
    task automatic consume_one(bit rv, logic [31:0] rpc, bit j,
                               logic [25:0] a26, bit b, bit t,
                               logic [15:0] imm, output logic [31:0] pc);
        bit got;
        got = 1'b0;
        pc  = 32'hDEAD_BEEF;
        for (int i = 0; i < 60 && !got; i++) begin
            set_dec(1'b1, rv, rpc, j, a26, b, t, imm);
            if (bus.instr_valid) begin
                pc  = bus.instr_pc;
                got = 1'b1;
            end
            tick();
        end
        set_dec(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL consume_timeout: got no instr_valid want one");
        end
    endtask

    task automatic next_pc(output logic [31:0] pc);
        consume_one(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0, pc);
    endtask

    task automatic redirect_to(logic [31:0] a);
        logic [31:0] dummy;
        consume_one(1'b1, a, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0, dummy);
    endtask

    logic [31:0] p;

    initial begin
        rst_n = 1'b0;
        set_dec(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        model_reset();
        @(negedge clk);
        do_reset();

        chk("idle_req_valid", bus.imem_req_valid, 32'h0);
        tick();
        chk("first_req_valid", bus.imem_req_valid, 32'h1);
        chk("first_req_addr", bus.imem_req_addr, 32'h0);
        tick();
        tick();
        chk("first_instr_valid", bus.instr_valid, 32'h1);
        chk("first_instr_pc", bus.instr_pc, 32'h0);
        chk("first_instruction", bus.instruction, 32'hA5A5_0000);

        repeat (10) tick();
        chk("full_no_req", bus.imem_req_valid, 32'h0);
        chk("full_head_pc", bus.instr_pc, 32'h0);
        next_pc(p); chk("seq0", p, 32'h0);
        next_pc(p); chk("seq1", p, 32'h4);
        next_pc(p); chk("seq2", p, 32'h8);
        next_pc(p); chk("seq3", p, 32'hC);

        redirect_to(32'h100);
        consume_one(1'b0, 32'h0, 1'b1, 26'h40, 1'b0, 1'b0, 16'h0, p);
        chk("jump_src", p, 32'h100);
        next_pc(p); chk("jump_tgt", p, 32'h100);

        redirect_to(32'h200);
        consume_one(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 1'b1, 16'hFFFE, p);
        chk("br_src", p, 32'h200);
        next_pc(p); chk("br_taken_tgt", p, 32'h1FC);
        redirect_to(32'h200);
        consume_one(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 1'b0, 16'hFFFE, p);
        next_pc(p); chk("br_not_taken", p, 32'h204);

        lat_min = 3; lat_max = 3;
        set_dec(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0, 16'h0);
        repeat (8) tick();
        redirect_to(32'h400);
        next_pc(p); chk("lat3_tgt", p, 32'h400);
        next_pc(p); chk("lat3_tgt_next", p, 32'h404);

        lat_min = 1; lat_max = 2;
        consume_one(1'b1, 32'h8000, 1'b1, 26'h3FF_FFFF, 1'b0, 1'b0,
                    16'h0, p);
        next_pc(p); chk("rv_over_jump", p, 32'h8000);
        redirect_to(32'h9003);
        next_pc(p); chk("misaligned_tgt", p, 32'h9000);
        redirect_to(32'hFFFF_FFFC);
        next_pc(p); chk("wrap_last", p, 32'hFFFF_FFFC);
        next_pc(p); chk("wrap_zero", p, 32'h0);

        lat_min = 1; lat_max = 3; ready_pct = 75;
        for (int n = 0; n < 3000; n++) begin
            set_dec($urandom_range(9, 0) < 6,
                    $urandom_range(19, 0) == 0, $urandom,
                    $urandom_range(19, 0) == 0, 26'($urandom),
                    $urandom_range(9, 0) == 0, $urandom_range(1, 0) == 1,
                    16'($urandom));
            tick();
            if (n == 1500) begin
                do_reset();
                next_pc(p); chk("post_reset_pc", p, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
